// File: rtl/flappy_engine.sv
// flappy_engine: frame-stepped Flappy Bird engine (bird physics, N pipes, LFSR gaps, scoring, WAIT/PLAY/OVER).
// Optional feature: define FLAPPY_SPEED_RAMP_EN to raise the scroll speed with the score.
module flappy_engine #(
    parameter int NUM_PIPES    = 3,
    parameter int COORD_W      = 12,
    parameter int SCR_W        = 640,
    parameter int SCR_H        = 480,
    parameter int PIPE_W       = 40,
    parameter int GAP_H        = 120,
    parameter int PIPE_SPACING = 220,
    parameter int BIRD_X       = 160,
    parameter int BIRD_SIZE    = 16,
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = 8,
    parameter int VMAX         = 10,
    parameter int SCROLL       = 2,
    parameter int SCORE_W      = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           vs,
    input  logic                           start,
    input  logic                           flap,
    output logic [NUM_PIPES*COORD_W-1:0]   pipe_x,
    output logic [NUM_PIPES*COORD_W-1:0]   pipe_y,
    output logic [COORD_W-1:0]             bird_x,
    output logic [COORD_W-1:0]             bird_y,
    output logic [SCORE_W-1:0]             score,
    output logic                           waiting,
    output logic                           playing,
    output logic                           over,
    output logic                           frame_done
);
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam int Y0        = (SCR_H - BIRD_SIZE) / 2;
    localparam int GAP_Y0    = (SCR_H - GAP_H) / 2;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    // Random gap tops span 40..295, so the whole gap must still fit on screen.
    if (40 + 255 + GAP_H > SCR_H) begin : g_geometry_check
        $error("flappy_engine: 40 + 255 + GAP_H exceeds SCR_H");
    end

    logic [1:0]                state;
    logic                      vs_q;
    logic                      tick;
    logic                      latch;
    logic                      frame_done_r;
    logic [15:0]               lfsr;
    logic                      lfsr_fb;
    logic [COORD_W-1:0]        bird_y_r;
    logic signed [COORD_W-1:0] vel_r;
    logic signed [COORD_W-1:0] px_r [NUM_PIPES];
    logic [COORD_W-1:0]        py_r [NUM_PIPES];
    logic [SCORE_W-1:0]        score_r;

    int                        scroll_eff;
    int                        vel_nxt;
    int                        y_nxt;
    int                        pass_cnt;
    int                        x_old;
    int                        x_new;
    int                        py_i;
    logic signed [COORD_W-1:0] px_nxt [NUM_PIPES];
    logic [COORD_W-1:0]        py_nxt [NUM_PIPES];
    logic [SCORE_W-1:0]        score_nxt;
    logic                      dead;

    function automatic int next_vel(input int v, input logic flapped);
        if (flapped) return -FLAP_VEL;
        if (v + GRAVITY > VMAX) return VMAX;
        return v + GRAVITY;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_score(input int s);
        if (s > SCORE_MAX) return SCORE_W'(SCORE_MAX);
        return SCORE_W'(s);
    endfunction

    assign tick    = vs & ~vs_q;
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_comb begin
        scroll_eff = SCROLL;
`ifdef FLAPPY_SPEED_RAMP_EN
        scroll_eff = SCROLL + int'(score_r[SCORE_W-1:3]);
        if (scroll_eff > 2 * SCROLL) scroll_eff = 2 * SCROLL;
`endif
        vel_nxt  = next_vel(int'(vel_r), latch | flap);
        y_nxt    = int'(bird_y_r) + vel_nxt;
        if (y_nxt < 0) y_nxt = 0;
        dead     = (y_nxt + BIRD_SIZE >= SCR_H);
        pass_cnt = 0;
        x_old    = 0;
        x_new    = 0;
        py_i     = 0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            x_old = int'(px_r[i]);
            // A pipe that would be fully off the left edge wraps behind the last one.
            if (x_old + PIPE_W <= scroll_eff) begin
                x_new     = x_old - scroll_eff + NUM_PIPES * PIPE_SPACING;
                py_nxt[i] = COORD_W'(40 + int'(lfsr[7:0]));
            end else begin
                x_new     = x_old - scroll_eff;
                py_nxt[i] = py_r[i];
            end
            px_nxt[i] = COORD_W'(x_new);
            if (x_old + PIPE_W >= BIRD_X && x_new + PIPE_W < BIRD_X) pass_cnt = pass_cnt + 1;
            py_i = int'(py_nxt[i]);
            if (BIRD_X + BIRD_SIZE > x_new && BIRD_X < x_new + PIPE_W &&
                (y_nxt < py_i || y_nxt + BIRD_SIZE > py_i + GAP_H)) dead = 1'b1;
        end
        score_nxt = sat_score(int'(score_r) + pass_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_WAIT;
            vs_q         <= 1'b0;
            lfsr         <= 16'hACE1;
            bird_y_r     <= COORD_W'(Y0);
            vel_r        <= '0;
            latch        <= 1'b0;
            score_r      <= '0;
            frame_done_r <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                px_r[i] <= COORD_W'(SCR_W + i * PIPE_SPACING);
                py_r[i] <= COORD_W'(GAP_Y0);
            end
        end else begin
            vs_q         <= vs;
            frame_done_r <= 1'b0;
            if (tick) lfsr <= {lfsr_fb, lfsr[15:1]};
            case (state)
                S_WAIT: begin
                    if (start) state <= S_PLAY;
                end
                S_PLAY: begin
                    if (tick) begin
                        vel_r        <= COORD_W'(vel_nxt);
                        bird_y_r     <= COORD_W'(y_nxt);
                        score_r      <= score_nxt;
                        latch        <= 1'b0;
                        frame_done_r <= 1'b1;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            px_r[i] <= px_nxt[i];
                            py_r[i] <= py_nxt[i];
                        end
                        if (dead) state <= S_OVER;
                    end else if (flap) begin
                        latch <= 1'b1;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        state    <= S_WAIT;
                        bird_y_r <= COORD_W'(Y0);
                        vel_r    <= '0;
                        latch    <= 1'b0;
                        score_r  <= '0;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            px_r[i] <= COORD_W'(SCR_W + i * PIPE_SPACING);
                            py_r[i] <= COORD_W'(GAP_Y0);
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
        assign pipe_x[g*COORD_W +: COORD_W] = px_r[g];
        assign pipe_y[g*COORD_W +: COORD_W] = py_r[g];
    end

    assign bird_x     = COORD_W'(BIRD_X);
    assign bird_y     = bird_y_r;
    assign score      = score_r;
    assign waiting    = (state == S_WAIT);
    assign playing    = (state == S_PLAY);
    assign over       = (state == S_OVER);
    assign frame_done = frame_done_r;
endmodule
